// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch stage: synchronous instruction memory feeding a small prefetch
// queue that hands {PC, IR} pairs to decode; redirects flush queue and in-flight read.
module fetch_prefetch_queue #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                IMEM_DEPTH  = 256,
  parameter int                QUEUE_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  localparam int               IDX_W       = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branch,
  input  logic              jump,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              imem_we,
  input  logic [IDX_W-1:0]  imem_waddr,
  input  logic [DATA_W-1:0] imem_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] PC,
  output logic [DATA_W-1:0] IR
);

  localparam int               QIDX_W = $clog2(QUEUE_DEPTH);
  localparam logic [QIDX_W:0]  Q_FULL = (QIDX_W+1)'(QUEUE_DEPTH);

  // Handshake: the head transfers to decode on a rising edge where out_valid and
  // out_ready are both high and no redirect is present; PC/IR hold while stalled.

  logic [DATA_W-1:0] mem [IMEM_DEPTH];
  logic [DATA_W-1:0] rdata;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;

  logic [DATA_W-1:0] q_data [QUEUE_DEPTH];
  logic [ADDR_W-1:0] q_pc   [QUEUE_DEPTH];
  logic [QIDX_W-1:0] wr_ptr;
  logic [QIDX_W-1:0] rd_ptr;
  logic [QIDX_W:0]   count;

  logic              redirect;
  logic [ADDR_W-1:0] target_raw;
  logic [ADDR_W-1:0] target;
  logic              issue;
  logic              push;
  logic              pop;

  always_comb begin
    redirect   = branch | jump;
    target_raw = branch ? branch_addr : jump_addr;
    target     = target_raw & ~ADDR_W'(3);
    // Credit counts the in-flight word so a returning read always finds a free slot.
    issue      = !redirect && ((count + {{QIDX_W{1'b0}}, inflight}) < Q_FULL);
    push       = !redirect && inflight;
    pop        = !redirect && out_valid && out_ready;
  end

  // Nonblocking read/write ordering gives old data on a same-index collision.
  always_ff @(posedge clk) begin
    if (imem_we) begin
      mem[imem_waddr] <= imem_wdata;
    end
    if (issue) begin
      rdata <= mem[fetch_pc[IDX_W+1:2]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      q_data[wr_ptr] <= rdata;
      q_pc[wr_ptr]   <= inflight_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else if (redirect) begin
      fetch_pc <= target;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + ADDR_W'(4);
      end
      if (push) begin
        wr_ptr <= wr_ptr + QIDX_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + QIDX_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (QIDX_W+1)'(1);
        2'b01:   count <= count - (QIDX_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    out_valid = (count != '0);
    PC        = out_valid ? q_pc[rd_ptr]   : '0;
    IR        = out_valid ? q_data[rd_ptr] : '0;
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue: expected {PC, IR} pairs are queued by the
// stimulus tasks and consumed by a monitor on every accepted handshake.
module tb_fetch_prefetch_queue;

  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int IMEM_DEPTH  = 256;
  localparam int QUEUE_DEPTH = 4;
  localparam int IDX_W       = 8;
  localparam int EW          = ADDR_W + DATA_W;

  logic              clk;
  logic              rst;
  logic              branch;
  logic              jump;
  logic [ADDR_W-1:0] branch_addr;
  logic [ADDR_W-1:0] jump_addr;
  logic              imem_we;
  logic [IDX_W-1:0]  imem_waddr;
  logic [DATA_W-1:0] imem_wdata;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] PC;
  logic [DATA_W-1:0] IR;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  int            n_cmp = 0;
  int            n_err = 0;

  fetch_prefetch_queue #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IMEM_DEPTH(IMEM_DEPTH),
    .QUEUE_DEPTH(QUEUE_DEPTH), .RESET_PC('0)
  ) dut (
    .clk(clk), .rst(rst), .branch(branch), .jump(jump),
    .branch_addr(branch_addr), .jump_addr(jump_addr),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .PC(PC), .IR(IR)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, summary %0d compared / %0d mismatched", n_cmp, n_err);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Program image is mem[i] = 0x1000 + i, so the word at any PC is known.
  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] pc);
    return 32'h1000 + {24'h0, pc[9:2]};
  endfunction

  task automatic push_stream(input logic [ADDR_W-1:0] pc0, input int n);
    logic [ADDR_W-1:0] pc;
    pc = pc0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({pc, mem_word(pc)});
      pc = pc + 32'd4;
    end
  endtask

  // Driver: apply a reset or redirect for one edge, then check the two-edge latency.
  task automatic restart(input logic do_rst, input logic do_br, input logic do_jp,
                         input logic [ADDR_W-1:0] ba, input logic [ADDR_W-1:0] ja,
                         input logic [ADDR_W-1:0] exp_pc, input logic [DATA_W-1:0] exp_ir,
                         input string tag, input int n);
    out_ready   = 1'b1;
    rst         = do_rst;
    branch      = do_br;
    jump        = do_jp;
    branch_addr = ba;
    jump_addr   = ja;
    exp_q.delete();
    push_stream(exp_pc, n);
    @(posedge clk); #1;
    rst    = 1'b0;
    branch = 1'b0;
    jump   = 1'b0;
    check({tag, "_flush_valid"}, out_valid, 1'b0);
    check({tag, "_flush_pc"}, PC, 0);
    check({tag, "_flush_ir"}, IR, 0);
    @(posedge clk); #1;
    check({tag, "_issue_valid"}, out_valid, 1'b0);
    @(posedge clk); #1;
    check({tag, "_first_valid"}, out_valid, 1'b1);
    check({tag, "_first_pc"}, PC, exp_pc);
    check({tag, "_first_ir"}, IR, exp_ir);
  endtask

  // Driver: accept until every queued expectation is consumed, then stall decode.
  task automatic drain(input bit toggle);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 200) begin
      if (toggle) out_ready = ~out_ready;
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    check("drain_done", exp_q.size() == 0, 1'b1);
    exp_q.delete();
  endtask

  // Scoreboard monitor: a transfer happens at the next edge when these hold.
  always @(negedge clk) begin
    if (!rst && !branch && !jump && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_out: got PC 0x%0h IR 0x%0h expected no output", PC, IR);
      end else begin
        mon_e = exp_q.pop_front();
        check("stream_pc", PC, mon_e[EW-1:DATA_W]);
        check("stream_ir", IR, mon_e[DATA_W-1:0]);
      end
    end
  end

  initial begin
    rst         = 1'b1;
    branch      = 1'b0;
    jump        = 1'b0;
    branch_addr = '0;
    jump_addr   = '0;
    imem_we     = 1'b0;
    imem_waddr  = '0;
    imem_wdata  = '0;
    out_ready   = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", out_valid, 1'b0);
    check("reset_pc", PC, 0);
    check("reset_ir", IR, 0);

    for (int i = 0; i < IMEM_DEPTH; i++) begin
      imem_we    = 1'b1;
      imem_waddr = i[7:0];
      imem_wdata = 32'h1000 + 32'(i);
      @(posedge clk); #1;
    end
    imem_we = 1'b0;

    // Streaming from reset, one instruction per cycle.
    restart(1'b1, 1'b0, 1'b0, '0, '0, 32'h0, 32'h1000, "rst", 8);
    drain(1'b0);

    // Backpressure: head frozen while decode stalls, then release in order.
    repeat (10) begin
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1'b1);
      check("hold_pc", PC, 32'h20);
      check("hold_ir", IR, 32'h1008);
    end
    push_stream(32'h20, 8);
    out_ready = 1'b1;
    drain(1'b1);

    // Branch with a non-empty queue.
    restart(1'b0, 1'b1, 1'b0, 32'h40, '0, 32'h40, 32'h1010, "branch", 6);
    drain(1'b0);

    // Branch wins over jump; jump target low bits cleared.
    restart(1'b0, 1'b1, 1'b1, 32'h80, 32'hC0, 32'h80, 32'h1020, "both", 6);
    drain(1'b0);
    restart(1'b0, 1'b0, 1'b1, '0, 32'h23, 32'h20, 32'h1008, "jump", 6);
    drain(1'b0);

    // Fetch across the top of memory aliases back to word 0.
    restart(1'b0, 1'b0, 1'b1, '0, 32'h3F8, 32'h3F8, 32'h10FE, "wrap", 6);
    drain(1'b0);

    // Reset with a partly filled queue and a read in flight.
    @(posedge clk); #1;
    restart(1'b1, 1'b0, 1'b0, '0, '0, 32'h0, 32'h1000, "rst2", 6);
    drain(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
